// File: rtl/led_frame_buffer_if.sv
// Bus bundle for led_frame_buffer: write port, swap request, read request/response.
// master drives writes and requests; slave (the frame buffer) drives colour and status.
interface led_frame_buffer_if #(
    parameter int NUM_LEDS = 20
);
    localparam int IDX_W = $clog2(NUM_LEDS);

    // Write port into the back bank
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [7:0]       wr_green;
    logic [7:0]       wr_red;
    logic [7:0]       wr_blue;

    // Bank control and read request from the strand driver
    logic             swap_req;
    logic [IDX_W:0]   next_led_request;
    logic             request_valid;
    logic [7:0]       brightness;

    // Read response
    logic [7:0]       green_out;
    logic [7:0]       red_out;
    logic [7:0]       blue_out;
    logic             color_valid;
    logic             swap_pending;
    logic             range_err;

    modport master (
        output wr_en, wr_addr, wr_green, wr_red, wr_blue,
        output swap_req, next_led_request, request_valid, brightness,
        input  green_out, red_out, blue_out, color_valid, swap_pending, range_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_green, wr_red, wr_blue,
        input  swap_req, next_led_request, request_valid, brightness,
        output green_out, red_out, blue_out, color_valid, swap_pending, range_err
    );
endinterface

// File: rtl/led_frame_buffer.sv
// Double-buffered LED colour store. Writes go to the back bank, the strand driver
// reads the front bank; banks swap (no copy) at a frame start once a swap is requested.
// Optional feature macro: LED_BRIGHTNESS_EN adds global brightness scaling and one
// extra output register stage (read latency 2 instead of 1).
module led_frame_buffer #(
    parameter int NUM_LEDS = 20
) (
    input logic               clk_in,
    input logic               rst,
    led_frame_buffer_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_LEDS);
    localparam logic [IDX_W:0] LED_COUNT = (IDX_W + 1)'(NUM_LEDS);

    // Two banks, indexed by bank number then LED; not reset
    logic [23:0] mem [2][NUM_LEDS];

    logic             bank_sel;
    logic             swap_pending_q;
    logic             frame_start;
    logic             do_swap;
    logic             bank_next;
    logic             req_in_range;
    logic             wr_in_range;
    logic [IDX_W-1:0] rd_idx;
    logic [23:0]      rd_word;

    logic             out_valid;
    logic             out_err;
    logic [23:0]      out_color;

    // Swap decision and read-side address decode for this cycle
    always_comb begin
        frame_start  = bus.request_valid && (bus.next_led_request == '0);
        do_swap      = frame_start && (swap_pending_q || bus.swap_req);
        // Post-swap bank select: the index-0 read of a swap cycle already sees the new front
        bank_next    = bank_sel ^ do_swap;
        req_in_range = bus.next_led_request < LED_COUNT;
        wr_in_range  = {1'b0, bus.wr_addr} < LED_COUNT;
        rd_idx       = bus.next_led_request[IDX_W-1:0];
        rd_word      = req_in_range ? mem[bank_next][rd_idx] : 24'd0;
    end

    // Bank select and pending-swap flag
    always_ff @(posedge clk_in) begin
        if (rst) begin
            bank_sel       <= 1'b0;
            swap_pending_q <= 1'b0;
        end else begin
            bank_sel <= bank_next;
            if (do_swap) begin
                swap_pending_q <= 1'b0;
            end else if (bus.swap_req) begin
                swap_pending_q <= 1'b1;
            end
        end
    end

    // Back-bank write; targets the post-swap back bank in a swap cycle
    always_ff @(posedge clk_in) begin
        if (!rst && bus.wr_en && wr_in_range) begin
            mem[~bank_next][bus.wr_addr] <= {bus.wr_green, bus.wr_red, bus.wr_blue};
        end
    end

`ifdef LED_BRIGHTNESS_EN
    logic        s1_valid;
    logic        s1_err;
    logic [23:0] s1_color;
    logic [7:0]  s1_bright;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        // c * (b + 1) never exceeds 16 bits, so the shifted result fits in 8
        return 8'((16'(c) * (16'(b) + 16'd1)) >> 8);
    endfunction

    // Read stage: capture raw colour and the brightness seen in the request cycle
    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_err    <= 1'b0;
            s1_color  <= 24'd0;
            s1_bright <= 8'd0;
        end else begin
            s1_valid <= bus.request_valid;
            s1_err   <= bus.request_valid && !req_in_range;
            if (bus.request_valid) begin
                s1_color  <= rd_word;
                s1_bright <= bus.brightness;
            end
        end
    end

    // Scale stage: apply brightness per channel; colours hold when idle
    always_ff @(posedge clk_in) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_color <= 24'd0;
        end else begin
            out_valid <= s1_valid;
            out_err   <= s1_err;
            if (s1_valid) begin
                out_color <= {scale(s1_color[23:16], s1_bright),
                              scale(s1_color[15:8], s1_bright),
                              scale(s1_color[7:0], s1_bright)};
            end
        end
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^bus.brightness;

    // Single read stage; colours hold when idle
    always_ff @(posedge clk_in) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_color <= 24'd0;
        end else begin
            out_valid <= bus.request_valid;
            out_err   <= bus.request_valid && !req_in_range;
            if (bus.request_valid) begin
                out_color <= rd_word;
            end
        end
    end
`endif

    assign bus.green_out    = out_color[23:16];
    assign bus.red_out      = out_color[15:8];
    assign bus.blue_out     = out_color[7:0];
    assign bus.color_valid  = out_valid;
    assign bus.range_err    = out_err;
    assign bus.swap_pending = swap_pending_q;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Self-checking bench for led_frame_buffer: bank-level behavioural model with a
// response queue, a per-cycle compare process, and directed literal checks.
`timescale 1ns/1ps
module tb_led_frame_buffer;
    localparam int NUM_LEDS = 20;
    localparam int IDX_W = 5;
`ifdef LED_BRIGHTNESS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [IDX_W:0] N_REQ = 6'(NUM_LEDS);
    localparam logic [IDX_W:0] N_WR = 6'(NUM_LEDS);

    logic clk_in = 1'b0;
    logic rst = 1'b1;
    always #5 clk_in = ~clk_in;

    led_frame_buffer_if #(.NUM_LEDS(NUM_LEDS)) bus ();

    led_frame_buffer #(.NUM_LEDS(NUM_LEDS)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;
    int pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int         due;
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
        bit         err;
    } resp_t;

    logic [23:0] m_bank [2][NUM_LEDS];
    bit          m_sel;
    bit          m_pend;
    resp_t       m_q[$];
    resp_t       m_t;
    int          edge_n = 0;
    bit          m_fs;
    bit          m_sw;
    logic [23:0] m_w;
    logic [7:0]  e_g = 8'd0;
    logic [7:0]  e_r = 8'd0;
    logic [7:0]  e_b = 8'd0;
    bit          e_valid = 1'b0;
    bit          e_err = 1'b0;

    function automatic logic [7:0] dim(input logic [7:0] c, input logic [7:0] br);
        int v;
        v = (int'(c) * (int'(br) + 1)) / 256;
        if (LAT == 2) return 8'(v);
        return c;
    endfunction

    always @(posedge clk_in) begin
        edge_n++;
        if (rst) begin
            m_sel   = 1'b0;
            m_pend  = 1'b0;
            m_q.delete();
            e_valid = 1'b0;
            e_err   = 1'b0;
            e_g     = 8'd0;
            e_r     = 8'd0;
            e_b     = 8'd0;
        end else begin
            m_fs = bus.request_valid && (bus.next_led_request == 6'd0);
            m_sw = m_fs && (m_pend || bus.swap_req);
            if (m_sw) begin
                m_sel  = ~m_sel;
                m_pend = 1'b0;
            end else if (bus.swap_req) begin
                m_pend = 1'b1;
            end
            if (bus.wr_en && ({1'b0, bus.wr_addr} < N_WR))
                m_bank[~m_sel][bus.wr_addr] = {bus.wr_green, bus.wr_red, bus.wr_blue};
            if (bus.request_valid) begin
                m_t.due = edge_n + LAT - 1;
                if (bus.next_led_request < N_REQ) begin
                    m_w     = m_bank[m_sel][5'(bus.next_led_request)];
                    m_t.g   = dim(m_w[23:16], bus.brightness);
                    m_t.r   = dim(m_w[15:8], bus.brightness);
                    m_t.b   = dim(m_w[7:0], bus.brightness);
                    m_t.err = 1'b0;
                end else begin
                    m_t.g   = 8'd0;
                    m_t.r   = 8'd0;
                    m_t.b   = 8'd0;
                    m_t.err = 1'b1;
                end
                m_q.push_back(m_t);
            end
            e_valid = 1'b0;
            e_err   = 1'b0;
            if (m_q.size() > 0 && m_q[0].due == edge_n) begin
                m_t     = m_q.pop_front();
                e_valid = 1'b1;
                e_err   = m_t.err;
                e_g     = m_t.g;
                e_r     = m_t.r;
                e_b     = m_t.b;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk_in) begin
        if (checking) begin
            check("cyc_color_valid", 32'(bus.color_valid), 32'(e_valid));
            check("cyc_range_err", 32'(bus.range_err), 32'(e_err));
            check("cyc_swap_pending", 32'(bus.swap_pending), 32'(m_pend));
            check("cyc_color", 32'({bus.green_out, bus.red_out, bus.blue_out}),
                  32'({e_g, e_r, e_b}));
        end
        if (bus.color_valid === 1'b1) pulses++;
    end

    // ---------------- stimulus ----------------
    function automatic logic [23:0] pat(input int k, input int i);
        return {8'(i * 3 + k * 7), 8'(i + 40 + k * 60), 8'(200 - i - k * 50)};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clr();
        bus.wr_en            = 1'b0;
        bus.wr_addr          = '0;
        bus.wr_green         = 8'd0;
        bus.wr_red           = 8'd0;
        bus.wr_blue          = 8'd0;
        bus.swap_req         = 1'b0;
        bus.next_led_request = '0;
        bus.request_valid    = 1'b0;
    endtask

    task automatic set_wr(input int addr, input logic [23:0] c);
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 5'(addr);
        bus.wr_green = c[23:16];
        bus.wr_red   = c[15:8];
        bus.wr_blue  = c[7:0];
    endtask

    task automatic wr(input int addr, input logic [23:0] c);
        set_wr(addr, c);
        tick();
        clr();
    endtask

    task automatic req(input int idx);
        bus.request_valid    = 1'b1;
        bus.next_led_request = 6'(idx);
        tick();
        clr();
    endtask

    task automatic expect_rsp(input string name, input logic [23:0] c, input logic err);
        check({name, "_valid"}, 32'(bus.color_valid), 32'd1);
        check({name, "_err"}, 32'(bus.range_err), 32'(err));
        check({name, "_color"}, 32'({bus.green_out, bus.red_out, bus.blue_out}), 32'(c));
    endtask

    int p0;

    initial begin
        clr();
        bus.brightness = 8'hFF;
        rst = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(bus.color_valid), 32'd0);
        check("rst_err", 32'(bus.range_err), 32'd0);
        check("rst_pending", 32'(bus.swap_pending), 32'd0);
        check("rst_color", 32'({bus.green_out, bus.red_out, bus.blue_out}), 32'd0);
        rst = 1'b0;
        checking = 1'b1;

        // Fill both banks so every later read is defined
        for (int i = 0; i < NUM_LEDS; i++) wr(i, pat(0, i));
        bus.swap_req = 1'b1;
        bus.request_valid = 1'b1;
        tick();
        clr();
        for (int i = 0; i < NUM_LEDS; i++) wr(i, pat(1, i));
        repeat (2) tick();

        // Write to back bank is not visible without a swap
        wr(5, 24'hFF00FF);
        req(5);
        repeat (LAT - 1) tick();
        expect_rsp("noswap_idx5", {8'd15, 8'd45, 8'd195}, 1'b0);

        // Write, request swap, then frame start swaps the banks
        wr(3, {8'd10, 8'd20, 8'd30});
        bus.swap_req = 1'b1;
        tick();
        clr();
        check("pending_set", 32'(bus.swap_pending), 32'd1);
        req(0);
        check("pending_clr", 32'(bus.swap_pending), 32'd0);
        req(3);
        repeat (LAT - 1) tick();
        expect_rsp("swap_idx3", {8'd10, 8'd20, 8'd30}, 1'b0);

        // Range boundary
        req(20);
        repeat (LAT - 1) tick();
        expect_rsp("range_idx20", 24'd0, 1'b1);
        req(19);
        repeat (LAT - 1) tick();
        expect_rsp("range_idx19", {8'd64, 8'd119, 8'd131}, 1'b0);
        req(63);
        repeat (LAT - 1) tick();
        expect_rsp("range_idx63", 24'd0, 1'b1);

        // Back-to-back requests 0..19
        repeat (2) tick();
        p0 = pulses;
        for (int i = 0; i < NUM_LEDS; i++) begin
            bus.request_valid = 1'b1;
            bus.next_led_request = 6'(i);
            tick();
        end
        clr();
        repeat (LAT + 1) tick();
        check("burst_pulses", 32'(pulses - p0), 32'd20);

        // Repeated swap_req while pending swaps only once
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b1;
        tick();
        clr();
        req(0);
        req(0);
        req(4);
        repeat (LAT - 1) tick();
        expect_rsp("dblswap_idx4", {8'd12, 8'd44, 8'd196}, 1'b0);

        // Swap coincident with idx0 request plus a write in the same cycle
        bus.swap_req = 1'b1;
        bus.request_valid = 1'b1;
        bus.next_led_request = 6'd0;
        set_wr(1, {8'd1, 8'd2, 8'd3});
        tick();
        clr();
        repeat (LAT - 1) tick();
        expect_rsp("coswap_idx0", {8'd7, 8'd100, 8'd150}, 1'b0);
        req(1);
        repeat (LAT - 1) tick();
        expect_rsp("coswap_idx1_old", {8'd10, 8'd101, 8'd149}, 1'b0);
        bus.swap_req = 1'b1;
        bus.request_valid = 1'b1;
        tick();
        clr();
        req(1);
        repeat (LAT - 1) tick();
        expect_rsp("coswap_idx1_new", {8'd1, 8'd2, 8'd3}, 1'b0);

        // Out-of-range write is ignored
        wr(25, 24'h123456);
        repeat (2) tick();

        // Reset in mid-pipeline drops the in-flight response
        bus.request_valid = 1'b1;
        bus.next_led_request = 6'd2;
        tick();
        clr();
        rst = 1'b1;
        tick();
        check("midrst_color", 32'({bus.green_out, bus.red_out, bus.blue_out}), 32'd0);
        rst = 1'b0;
        tick();
        check("midrst_valid", 32'(bus.color_valid), 32'd0);
        req(5);
        repeat (LAT - 1) tick();
        expect_rsp("postrst_idx5", 24'hFF00FF, 1'b0);

`ifdef LED_BRIGHTNESS_EN
        wr(7, {8'd50, 8'd200, 8'd100});
        bus.swap_req = 1'b1;
        bus.request_valid = 1'b1;
        tick();
        clr();
        bus.brightness = 8'd127;
        req(7);
        bus.brightness = 8'hFF;
        tick();
        expect_rsp("bright127", {8'd25, 8'd100, 8'd50}, 1'b0);
        req(7);
        tick();
        expect_rsp("bright255", {8'd50, 8'd200, 8'd100}, 1'b0);
        bus.brightness = 8'd0;
        req(7);
        bus.brightness = 8'hFF;
        tick();
        expect_rsp("bright0", 24'd0, 1'b0);
`else
        bus.brightness = 8'd0;
        req(5);
        bus.brightness = 8'hFF;
        expect_rsp("bright_ignored", 24'hFF00FF, 1'b0);
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
